// File: rtl/y86_fde_core.sv
// y86_fde_core: sequential Y86-64 fetch/decode, register file and execute ALU.
// Decode, register reads, ALU and condition evaluation are combinational from
// PC/Instruction; the register file and the {ZF,SF,OF} register update on the
// rising edge of Clk when the instruction is valid.
// Optional build macro Y86_DBG_PORT_EN adds dbg_sel/dbg_data for a
// combinational register peek.
module y86_fde_core #(
    parameter int          MEM_SIZE   = 256,
    parameter logic [63:0] STACK_INIT = 64'hF0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [63:0] PC,
    input  logic [79:0] Instruction,
    input  logic [63:0] valM,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [63:0] valE,
    output logic        Cnd,
    output logic [2:0]  CC,
    output logic        INS,
    output logic        ADR,
    output logic        HLT
`ifdef Y86_DBG_PORT_EN
    ,
    input  logic [3:0]  dbg_sel,
    output logic [63:0] dbg_data
`endif
);

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;
    localparam logic [3:0] R_RSP   = 4'h4;
    localparam logic [3:0] R_NONE  = 4'hF;

    logic [63:0] r_regs [15];
    logic [2:0]  r_cc;

    logic [7:0]  w_byte [10];
    logic        w_has_reg;
    logic [3:0]  w_len;
    logic [3:0]  w_src_a;
    logic [3:0]  w_src_b;
    logic [3:0]  w_dst_e;
    logic [3:0]  w_dst_m;
    logic        w_zf;
    logic        w_sf;
    logic        w_of;
    logic        w_ok;
    logic [2:0]  w_cc_next;

    // Slice the 10-byte window; byte 0 sits in the top bits.
    for (genvar k = 0; k < 10; k++) begin : g_byte
        assign w_byte[k] = Instruction[79-8*k -: 8];
    end

    assign icode = w_byte[0][7:4];
    assign ifun  = w_byte[0][3:0];
    assign CC    = r_cc;
    assign w_zf  = r_cc[2];
    assign w_sf  = r_cc[1];
    assign w_of  = r_cc[0];

    // Fetch decode: length, register byte, constant, next PC, exceptions.
    always_comb begin
        w_len     = 4'd1;
        w_has_reg = 1'b0;
        valC      = 64'd0;
        case (icode)
            I_RRMOV, I_OPQ, I_PUSH, I_POP: begin
                w_len     = 4'd2;
                w_has_reg = 1'b1;
            end
            I_JXX, I_CALL: begin
                w_len = 4'd9;
                valC  = {w_byte[8], w_byte[7], w_byte[6], w_byte[5],
                         w_byte[4], w_byte[3], w_byte[2], w_byte[1]};
            end
            I_IRMOV, I_RMMOV, I_MRMOV: begin
                w_len     = 4'd10;
                w_has_reg = 1'b1;
                valC      = {w_byte[9], w_byte[8], w_byte[7], w_byte[6],
                             w_byte[5], w_byte[4], w_byte[3], w_byte[2]};
            end
            default: w_len = 4'd1;
        endcase
        rA   = w_has_reg ? w_byte[1][7:4] : R_NONE;
        rB   = w_has_reg ? w_byte[1][3:0] : R_NONE;
        valP = PC + 64'(w_len);
        HLT  = (icode == I_HALT);
        // PC below MEM_SIZE is checked first, so PC + length cannot wrap.
        ADR  = (PC >= 64'(MEM_SIZE)) || ((PC + 64'(w_len)) > 64'(MEM_SIZE));
        if (icode > I_POP)
            INS = 1'b1;
        else if (icode == I_OPQ)
            INS = (ifun > 4'd3);
        else if ((icode == I_RRMOV) || (icode == I_JXX))
            INS = (ifun > 4'd6);
        else
            INS = (ifun != 4'd0);
    end

    // Source register selection and combinational register reads.
    always_comb begin
        case (icode)
            I_RRMOV, I_RMMOV, I_OPQ, I_PUSH: w_src_a = rA;
            I_RET, I_POP:                    w_src_a = R_RSP;
            default:                         w_src_a = R_NONE;
        endcase
        case (icode)
            I_RMMOV, I_MRMOV, I_OPQ:         w_src_b = rB;
            I_CALL, I_RET, I_PUSH, I_POP:    w_src_b = R_RSP;
            default:                         w_src_b = R_NONE;
        endcase
        valA = (w_src_a == R_NONE) ? 64'd0 : r_regs[w_src_a];
        valB = (w_src_b == R_NONE) ? 64'd0 : r_regs[w_src_b];
    end

    // Condition evaluation from the registered flags.
    always_comb begin
        case (ifun)
            4'd0:    Cnd = 1'b1;
            4'd1:    Cnd = (w_sf ^ w_of) | w_zf;
            4'd2:    Cnd = w_sf ^ w_of;
            4'd3:    Cnd = w_zf;
            4'd4:    Cnd = ~w_zf;
            4'd5:    Cnd = ~(w_sf ^ w_of);
            4'd6:    Cnd = ~(w_sf ^ w_of) & ~w_zf;
            default: Cnd = 1'b0;
        endcase
    end

    // ALU and the flag values an OPq would load.
    always_comb begin
        valE      = 64'd0;
        w_cc_next = r_cc;
        case (icode)
            I_OPQ: begin
                case (ifun)
                    4'd0:    valE = valB + valA;
                    4'd1:    valE = valB - valA;
                    4'd2:    valE = valB & valA;
                    4'd3:    valE = valB ^ valA;
                    default: valE = 64'd0;
                endcase
                w_cc_next[2] = (valE == 64'd0);
                w_cc_next[1] = valE[63];
                if (ifun == 4'd0)
                    w_cc_next[0] = (valA[63] == valB[63]) && (valE[63] != valA[63]);
                else if (ifun == 4'd1)
                    w_cc_next[0] = (valA[63] != valB[63]) && (valE[63] != valB[63]);
                else
                    w_cc_next[0] = 1'b0;
            end
            I_RRMOV:          valE = valA;
            I_IRMOV:          valE = valC;
            I_RMMOV, I_MRMOV: valE = valB + valC;
            I_CALL, I_PUSH:   valE = valB - 64'd8;
            I_RET, I_POP:     valE = valB + 64'd8;
            default:          valE = 64'd0;
        endcase
    end

    // Writeback destinations; a faulting or halting instruction commits nothing.
    always_comb begin
        case (icode)
            I_IRMOV, I_OPQ:               w_dst_e = rB;
            I_RRMOV:                      w_dst_e = Cnd ? rB : R_NONE;
            I_CALL, I_RET, I_PUSH, I_POP: w_dst_e = R_RSP;
            default:                      w_dst_e = R_NONE;
        endcase
        w_dst_m = ((icode == I_MRMOV) || (icode == I_POP)) ? rA : R_NONE;
        w_ok    = ~(INS | ADR | HLT);
    end

    // Register file write; the memory port wins a same-register collision.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 15; i++)
                r_regs[i] <= (i == 4) ? STACK_INIT : 64'd0;
        end else if (w_ok) begin
            for (int i = 0; i < 15; i++) begin
                if (w_dst_m == 4'(i))
                    r_regs[i] <= valM;
                else if (w_dst_e == 4'(i))
                    r_regs[i] <= valE;
            end
        end
    end

    // Condition-code register, loaded only by valid OPq instructions.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            r_cc <= 3'b000;
        else if (w_ok && (icode == I_OPQ))
            r_cc <= w_cc_next;
    end

`ifdef Y86_DBG_PORT_EN
    assign dbg_data = (dbg_sel == R_NONE) ? 64'd0 : r_regs[dbg_sel];
`endif

endmodule

// File: tb/tb_y86_fde_core.sv
// Self-checking bench for y86_fde_core: directed cases plus random instruction
// streams compared against an architectural model of the register file and CC.
module tb_y86_fde_core;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [63:0] PC;
    logic [79:0] Instruction;
    logic [63:0] valM;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP, valA, valB, valE;
    logic        Cnd, INS, ADR, HLT;
    logic [2:0]  CC;

    y86_fde_core dut (
        .Clk(Clk), .Reset_n(Reset_n), .PC(PC), .Instruction(Instruction),
        .valM(valM), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .valA(valA), .valB(valB), .valE(valE),
        .Cnd(Cnd), .CC(CC), .INS(INS), .ADR(ADR), .HLT(HLT)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Architectural model state.
    logic [63:0] m_reg [15];
    logic [2:0]  m_cc;

    // Expected values for the instruction currently applied.
    logic [7:0]  ib [10];
    logic [3:0]  e_icode, e_ifun, e_ra, e_rb, e_dste, e_dstm;
    logic [63:0] e_valc, e_valp, e_vala, e_valb, e_vale, e_vm;
    logic        e_cnd, e_ins, e_adr, e_hlt;
    logic [2:0]  e_ncc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rd(input logic [3:0] r);
        return (r == 4'hF) ? 64'd0 : m_reg[r];
    endfunction

    function automatic logic [63:0] bswap(input logic [63:0] v);
        logic [63:0] o;
        for (int k = 0; k < 8; k++) o[63-8*k -: 8] = v[8*k +: 8];
        return o;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_reg[i] = (i == 4) ? 64'hF0 : 64'd0;
        m_cc = 3'b000;
    endtask

    task automatic predict(input logic [63:0] pc);
        logic [3:0] ic, fn, sa, sb;
        logic [63:0] a, b, e, c;
        int len;
        logic zf, sf, of;
        ic = ib[0][7:4];
        fn = ib[0][3:0];
        if (ic inside {0, 1, 9})            len = 1;
        else if (ic inside {2, 6, 10, 11})  len = 2;
        else if (ic inside {7, 8})          len = 9;
        else if (ic inside {3, 4, 5})       len = 10;
        else                                len = 1;
        e_icode = ic;
        e_ifun  = fn;
        e_ra = (ic inside {2, 3, 4, 5, 6, 10, 11}) ? ib[1][7:4] : 4'hF;
        e_rb = (ic inside {2, 3, 4, 5, 6, 10, 11}) ? ib[1][3:0] : 4'hF;
        c = 64'd0;
        if (ic inside {7, 8})
            for (int k = 8; k >= 1; k--) c = (c << 8) | 64'(ib[k]);
        else if (ic inside {3, 4, 5})
            for (int k = 9; k >= 2; k--) c = (c << 8) | 64'(ib[k]);
        e_valc = c;
        e_valp = pc + 64'(len);
        e_ins = (ic > 11) || (ic == 6 && fn > 3) || ((ic == 2 || ic == 7) && fn > 6)
              || (!(ic inside {2, 6, 7}) && fn != 0);
        e_hlt = (ic == 0);
        e_adr = (pc >= 256) || (pc + 64'(len) > 256);
        sa = (ic inside {2, 4, 6, 10}) ? e_ra : (ic inside {9, 11}) ? 4'd4 : 4'hF;
        sb = (ic inside {4, 5, 6}) ? e_rb : (ic inside {8, 9, 10, 11}) ? 4'd4 : 4'hF;
        a = rd(sa);
        b = rd(sb);
        e_vala = a;
        e_valb = b;
        zf = m_cc[2]; sf = m_cc[1]; of = m_cc[0];
        case (fn)
            0: e_cnd = 1;
            1: e_cnd = (sf ^ of) | zf;
            2: e_cnd = sf ^ of;
            3: e_cnd = zf;
            4: e_cnd = !zf;
            5: e_cnd = !(sf ^ of);
            6: e_cnd = !(sf ^ of) && !zf;
            default: e_cnd = 0;
        endcase
        e = 64'd0;
        case (ic)
            6: case (fn)
                   0: e = b + a;
                   1: e = b - a;
                   2: e = b & a;
                   3: e = b ^ a;
                   default: e = 64'd0;
               endcase
            2: e = a;
            3: e = c;
            4, 5: e = b + c;
            8, 10: e = b - 64'd8;
            9, 11: e = b + 64'd8;
            default: e = 64'd0;
        endcase
        e_vale = e;
        e_ncc[2] = (e == 0);
        e_ncc[1] = e[63];
        e_ncc[0] = (fn == 0) ? ((a[63] == b[63]) && (e[63] != a[63])) :
                   (fn == 1) ? ((a[63] != b[63]) && (e[63] != b[63])) : 1'b0;
        e_dste = (ic inside {3, 6}) ? e_rb : (ic == 2 && e_cnd) ? e_rb :
                 (ic inside {8, 9, 10, 11}) ? 4'd4 : 4'hF;
        e_dstm = (ic inside {5, 11}) ? e_ra : 4'hF;
    endtask

    task automatic drive_and_check(input logic [63:0] pc, input logic [79:0] ins, input logic [63:0] vm);
        @(negedge Clk);
        for (int k = 0; k < 10; k++) ib[k] = ins[79-8*k -: 8];
        PC = pc;
        Instruction = ins;
        valM = vm;
        e_vm = vm;
        predict(pc);
        #2;
        chk("icode", 64'(icode), 64'(e_icode));
        chk("ifun",  64'(ifun),  64'(e_ifun));
        chk("rA",    64'(rA),    64'(e_ra));
        chk("rB",    64'(rB),    64'(e_rb));
        chk("valC",  valC, e_valc);
        chk("valP",  valP, e_valp);
        chk("valA",  valA, e_vala);
        chk("valB",  valB, e_valb);
        chk("valE",  valE, e_vale);
        chk("Cnd",   64'(Cnd), 64'(e_cnd));
        chk("CC",    64'(CC),  64'(m_cc));
        chk("INS",   64'(INS), 64'(e_ins));
        chk("ADR",   64'(ADR), 64'(e_adr));
        chk("HLT",   64'(HLT), 64'(e_hlt));
    endtask

    task automatic commit();
        @(posedge Clk);
        #1;
        if (!(e_ins || e_adr || e_hlt)) begin
            if (e_dste != 4'hF) m_reg[e_dste] = e_vale;
            if (e_dstm != 4'hF) m_reg[e_dstm] = e_vm;
            if (e_icode == 4'h6) m_cc = e_ncc;
        end
    endtask

    task automatic set_reg(input logic [3:0] r, input logic [63:0] v);
        drive_and_check(64'd0, {8'h30, 4'hF, r, bswap(v)}, 64'd0);
        commit();
    endtask

    // An OPq with ifun 4 is invalid, so it reads rA/rB without committing.
    task automatic rd_reg(input logic [3:0] r);
        drive_and_check(64'd0, {8'h64, r, 4'hF, 64'd0}, 64'd0);
    endtask

    task automatic rd_all();
        for (int r = 0; r < 15; r++) rd_reg(4'(r));
    endtask

    task automatic rand_instr();
        logic [3:0] ic, fn;
        logic [79:0] ins;
        logic [63:0] pc;
        int mx;
        ic = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 11)) : 4'($urandom_range(0, 15));
        mx = (ic == 6) ? 3 : (ic == 2 || ic == 7) ? 6 : 0;
        fn = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, mx)) : 4'($urandom_range(0, 15));
        ins = {ic, fn, 8'($urandom), 32'($urandom), 32'($urandom)};
        pc = ($urandom_range(0, 99) < 85) ? 64'($urandom_range(0, 240)) : 64'($urandom_range(240, 270));
        drive_and_check(pc, ins, {32'($urandom), 32'($urandom)});
        commit();
    endtask

    initial begin
        Reset_n = 1'b0;
        PC = 64'd0;
        Instruction = 80'd0;
        valM = 64'd0;
        model_reset();
        #12 Reset_n = 1'b1;

        chk("rst_cc", 64'(CC), 64'd0);
        rd_all();

        // irmovq $0x100, %rax
        drive_and_check(64'd0, 80'h30F0_0001_0000_0000_0000, 64'd0);
        chk("irm_icode", 64'(icode), 64'd3);
        chk("irm_rb", 64'(rB), 64'd0);
        chk("irm_valc", valC, 64'h100);
        chk("irm_valp", valP, 64'd10);
        commit();
        rd_reg(4'd0);
        chk("irm_rax", valA, 64'h100);

        // addq %rax, %rdx with 5 + 7
        set_reg(4'd0, 64'd5);
        set_reg(4'd2, 64'd7);
        drive_and_check(64'd0, {16'h6002, 64'd0}, 64'd0);
        chk("add_vale", valE, 64'd12);
        commit();
        chk("add_cc", 64'(CC), 64'b000);
        rd_reg(4'd2);
        chk("add_rdx", valA, 64'd12);

        // subq equal values, then je / jne
        set_reg(4'd0, 64'd9);
        set_reg(4'd2, 64'd9);
        drive_and_check(64'd0, {16'h6102, 64'd0}, 64'd0);
        commit();
        chk("sub_cc", 64'(CC), 64'b100);
        drive_and_check(64'd0, {8'h73, 72'h40_0000_0000_0000_0000}, 64'd0);
        chk("je_cnd", 64'(Cnd), 64'd1);
        commit();
        drive_and_check(64'd0, {8'h74, 72'h40_0000_0000_0000_0000}, 64'd0);
        chk("jne_cnd", 64'(Cnd), 64'd0);
        commit();

        // signed overflow on addq
        set_reg(4'd0, 64'd1);
        set_reg(4'd2, 64'h7FFF_FFFF_FFFF_FFFF);
        drive_and_check(64'd0, {16'h6002, 64'd0}, 64'd0);
        chk("ovf_vale", valE, 64'h8000_0000_0000_0000);
        commit();
        chk("ovf_cc", 64'(CC), 64'b011);

        // popq %rsp: the loaded value wins over the stack increment
        drive_and_check(64'd20, {16'hB04F, 64'd0}, 64'h1234_5678);
        commit();
        rd_reg(4'd4);
        chk("pop_rsp", valA, 64'h1234_5678);

        // invalid, halt and address faults commit nothing
        drive_and_check(64'd0, {8'hC0, 72'd0}, 64'd0);
        chk("bad_ins", 64'(INS), 64'd1);
        commit();
        drive_and_check(64'd5, {8'h00, 72'd0}, 64'd0);
        chk("hlt", 64'(HLT), 64'd1);
        chk("hlt_valp", valP, 64'd6);
        commit();
        drive_and_check(64'd250, 80'h30F1_0001_0000_0000_0000, 64'd0);
        chk("adr", 64'(ADR), 64'd1);
        commit();
        chk("fault_cc", 64'(CC), 64'b011);
        rd_all();

        for (int n = 0; n < 400; n++) begin
            rand_instr();
            if (n % 100 == 99) rd_all();
        end

        // asynchronous reset mid-run, observed before any clock edge
        @(negedge Clk);
        Instruction = {16'h6440, 64'd0};
        PC = 64'd0;
        #1 Reset_n = 1'b0;
        #1;
        chk("arst_rsp", valA, 64'hF0);
        chk("arst_rax", valB, 64'd0);
        chk("arst_cc", 64'(CC), 64'd0);
        model_reset();
        rd_all();
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int n = 0; n < 200; n++) rand_instr();
        rd_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
